// File: rtl/nco_ctrl_pkg.sv
// Shared NCO control types: scheduler FSM states, hop table entry layout and
// the NCO pipeline latency default shared with the NCO wrapper.
package nco_ctrl_pkg;

  localparam int unsigned NCO_LAT_DEF = 10;
  localparam int unsigned HOP_APR     = 32;
  localparam int unsigned HOP_DWW     = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [HOP_APR-1:0] inc;
    logic [HOP_DWW-1:0] dwell;
  } hop_entry_t;

endpackage

// File: rtl/nco_hop_sched_if.sv
// Control/config side and NCO side signals of the hop scheduler.
interface nco_hop_sched_if #(
  parameter int unsigned APR      = 32,
  parameter int unsigned LOG2NHOP = 3,
  parameter int unsigned DWW      = 16
) ();

  logic                cfg_we;
  logic [LOG2NHOP-1:0] cfg_addr;
  logic [APR-1:0]      cfg_inc;
  logic [DWW-1:0]      cfg_dwell;
  logic [LOG2NHOP-1:0] last_idx;
  logic                loop_en;
  logic                start;
  logic                stop;

  logic [APR-1:0]      phi_inc_o;
  logic                nco_clken;
  logic [LOG2NHOP-1:0] hop_idx;
  logic                busy;
  logic                settled;
  logic                done;

  modport master (
    output cfg_we, cfg_addr, cfg_inc, cfg_dwell, last_idx, loop_en, start, stop,
    input  phi_inc_o, nco_clken, hop_idx, busy, settled, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_inc, cfg_dwell, last_idx, loop_en, start, stop,
    output phi_inc_o, nco_clken, hop_idx, busy, settled, done
  );

endinterface

// File: rtl/nco_hop_table.sv
// Hop register file: one synchronous write port, one combinational read port,
// cleared on reset.
module nco_hop_table
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned NHOP     = 8,
  parameter int unsigned LOG2NHOP = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [LOG2NHOP-1:0] wr_addr,
  input  hop_entry_t          wr_entry,
  input  logic [LOG2NHOP-1:0] rd_addr,
  output hop_entry_t          rd_entry
);

  hop_entry_t mem [NHOP];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NHOP; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/nco_hop_sched.sv
// Frequency-hop scheduler: steps the NCO phase increment through the hop table,
// tracks NCO settling per hop and flushes the NCO pipeline before stopping.
module nco_hop_sched
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned APR      = nco_ctrl_pkg::HOP_APR,
  parameter int unsigned NHOP     = 8,
  parameter int unsigned LOG2NHOP = 3,
  parameter int unsigned DWW      = nco_ctrl_pkg::HOP_DWW,
  parameter int unsigned NCO_LAT  = nco_ctrl_pkg::NCO_LAT_DEF
) (
  input logic             clk,
  input logic             reset,
  nco_hop_sched_if.slave  bus
);

  localparam int unsigned CW = $clog2(NCO_LAT + 1);

  state_t              state;
  logic [LOG2NHOP-1:0] last_q;
  logic                loop_q;
  logic [DWW-1:0]      dwell_cnt;
  logic [CW-1:0]       settle_cnt;
  logic [CW-1:0]       drain_cnt;

  logic                last_hop;
  logic                load_hop;
  logic [LOG2NHOP-1:0] next_idx;
  logic [LOG2NHOP-1:0] rd_addr;
  logic [DWW-1:0]      dwell_ld;
  hop_entry_t          wr_entry;
  hop_entry_t          rd_entry;

  assign wr_entry = '{inc: HOP_APR'(bus.cfg_inc), dwell: HOP_DWW'(bus.cfg_dwell)};

  nco_hop_table #(
    .NHOP     (NHOP),
    .LOG2NHOP (LOG2NHOP)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .we       (bus.cfg_we),
    .wr_addr  (bus.cfg_addr),
    .wr_entry (wr_entry),
    .rd_addr  (rd_addr),
    .rd_entry (rd_entry)
  );

  // The read port addresses entry 0 while idle and the following hop while running,
  // so a load always picks up the table contents at the moment of the load.
  always_comb begin
    last_hop = (bus.hop_idx == last_q);
    next_idx = last_hop ? '0 : bus.hop_idx + LOG2NHOP'(1);
    rd_addr  = (state == RUN) ? next_idx : '0;
    dwell_ld = (rd_entry.dwell == '0) ? '0 : DWW'(rd_entry.dwell) - DWW'(1);
    load_hop = 1'b0;
    if (state == IDLE) begin
      load_hop = bus.start && !bus.stop;
    end else if (state == RUN) begin
      load_hop = !bus.stop && (dwell_cnt == '0) && (!last_hop || loop_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_q        <= '0;
      loop_q        <= 1'b0;
      dwell_cnt     <= '0;
      settle_cnt    <= '0;
      drain_cnt     <= '0;
      bus.phi_inc_o <= '0;
      bus.nco_clken <= 1'b0;
      bus.hop_idx   <= '0;
      bus.busy      <= 1'b0;
      bus.settled   <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;

      if (state != IDLE && settle_cnt != '0) begin
        settle_cnt  <= settle_cnt - CW'(1);
        bus.settled <= (settle_cnt == CW'(1));
      end

      if (load_hop) begin
        bus.hop_idx   <= rd_addr;
        bus.phi_inc_o <= APR'(rd_entry.inc);
        dwell_cnt     <= dwell_ld;
        settle_cnt    <= CW'(NCO_LAT);
        bus.settled   <= (NCO_LAT == 0);
      end

      case (state)
        IDLE: begin
          if (load_hop) begin
            state         <= RUN;
            last_q        <= bus.last_idx;
            loop_q        <= bus.loop_en;
            bus.nco_clken <= 1'b1;
            bus.busy      <= 1'b1;
          end
        end
        RUN: begin
          if (bus.stop || (dwell_cnt == '0 && last_hop && !loop_q)) begin
            state     <= DRAIN;
            drain_cnt <= CW'(NCO_LAT - 1);
          end else if (!load_hop) begin
            dwell_cnt <= dwell_cnt - DWW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state         <= IDLE;
            bus.done      <= 1'b1;
            bus.nco_clken <= 1'b0;
            bus.busy      <= 1'b0;
            bus.settled   <= 1'b0;
            settle_cnt    <= '0;
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_hop_sched.sv
// Directed bench for nco_hop_sched; cycle k counts negedges after the start edge.
module tb_nco_hop_sched;

  localparam logic [31:0] INC_A = 32'h0147AE14;
  localparam logic [31:0] INC_B = 32'h028F5C28;
  localparam logic [31:0] INC_C = 32'h0A3D70A4;
  localparam logic [31:0] INC_X = 32'h00123456;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] e_phi;
  logic [2:0]  e_hop;
  logic        e_busy;
  logic        e_done;
  logic        e_set;

  nco_hop_sched_if #(.APR(32), .LOG2NHOP(3), .DWW(16)) bus ();

  nco_hop_sched #(
    .APR      (32),
    .NHOP     (8),
    .LOG2NHOP (3),
    .DWW      (16),
    .NCO_LAT  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] inc, input logic [15:0] dw);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_inc   = inc;
    bus.cfg_dwell = dw;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.phi_inc_o !== 32'h0) begin bad++; $display("FAIL reset_phi got=%h exp=0", bus.phi_inc_o); end
    total++; if (bus.nco_clken !== 1'b0) begin bad++; $display("FAIL reset_clken got=%b exp=0", bus.nco_clken); end
    total++; if (bus.hop_idx !== 3'd0) begin bad++; $display("FAIL reset_hop got=%0d exp=0", bus.hop_idx); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.settled !== 1'b0) begin bad++; $display("FAIL reset_settled got=%b exp=0", bus.settled); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Empty table: one 1-cycle hop of increment 0, 10 drain cycles, done at k=12.
  task automatic test_empty_start();
    bus.last_idx = 3'd0;
    bus.loop_en  = 1'b0;
    pulse_start();
    for (int k = 1; k <= 13; k++) begin
      e_busy = (k <= 11);
      e_done = (k == 12);
      total++; if (bus.phi_inc_o !== 32'h0) begin bad++; $display("FAIL empty_phi k=%0d got=%h exp=0", k, bus.phi_inc_o); end
      total++; if (bus.busy !== e_busy) begin bad++; $display("FAIL empty_busy k=%0d got=%b exp=%b", k, bus.busy, e_busy); end
      total++; if (bus.nco_clken !== e_busy) begin bad++; $display("FAIL empty_clken k=%0d got=%b exp=%b", k, bus.nco_clken, e_busy); end
      total++; if (bus.done !== e_done) begin bad++; $display("FAIL empty_done k=%0d got=%b exp=%b", k, bus.done, e_done); end
      @(negedge clk);
    end
  endtask

  task automatic test_single_pass();
    cfg_write(3'd0, INC_A, 16'd20);
    cfg_write(3'd1, INC_B, 16'd30);
    bus.last_idx = 3'd1;
    bus.loop_en  = 1'b0;
    pulse_start();
    // changing these after start must not matter: they are latched at start
    bus.last_idx = 3'd0;
    bus.loop_en  = 1'b1;
    for (int k = 1; k <= 62; k++) begin
      e_phi  = (k <= 20) ? INC_A : INC_B;
      e_hop  = (k <= 20) ? 3'd0 : 3'd1;
      e_busy = (k <= 60);
      e_done = (k == 61);
      e_set  = (k >= 11 && k <= 20) || (k >= 31 && k <= 50);
      total++; if (bus.phi_inc_o !== e_phi) begin bad++; $display("FAIL single_phi k=%0d got=%h exp=%h", k, bus.phi_inc_o, e_phi); end
      total++; if (bus.busy !== e_busy) begin bad++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, bus.busy, e_busy); end
      total++; if (bus.nco_clken !== e_busy) begin bad++; $display("FAIL single_clken k=%0d got=%b exp=%b", k, bus.nco_clken, e_busy); end
      total++; if (bus.done !== e_done) begin bad++; $display("FAIL single_done k=%0d got=%b exp=%b", k, bus.done, e_done); end
      if (k <= 60) begin
        total++; if (bus.hop_idx !== e_hop) begin bad++; $display("FAIL single_hop k=%0d got=%0d exp=%0d", k, bus.hop_idx, e_hop); end
      end
      if (k <= 50 || k >= 61) begin
        total++; if (bus.settled !== (e_set && k <= 50)) begin bad++; $display("FAIL single_settled k=%0d got=%b exp=%b", k, bus.settled, e_set); end
      end
      @(negedge clk);
    end
  endtask

  // Looping run with a rewrite of active entry 1 at k=25 and stop during k=73.
  task automatic test_loop();
    cfg_write(3'd0, INC_A, 16'd20);
    cfg_write(3'd1, INC_B, 16'd30);
    bus.last_idx = 3'd1;
    bus.loop_en  = 1'b1;
    pulse_start();
    for (int k = 1; k <= 86; k++) begin
      e_phi  = (k <= 20) ? INC_A : (k <= 50) ? INC_B : (k <= 70) ? INC_A : INC_C;
      e_hop  = (k <= 20) ? 3'd0 : (k <= 50) ? 3'd1 : (k <= 70) ? 3'd0 : 3'd1;
      e_busy = (k <= 83);
      e_done = (k == 84);
      e_set  = (k >= 11 && k <= 20) || (k >= 31 && k <= 50) || (k >= 61 && k <= 70);
      total++; if (bus.phi_inc_o !== e_phi) begin bad++; $display("FAIL loop_phi k=%0d got=%h exp=%h", k, bus.phi_inc_o, e_phi); end
      total++; if (bus.busy !== e_busy) begin bad++; $display("FAIL loop_busy k=%0d got=%b exp=%b", k, bus.busy, e_busy); end
      total++; if (bus.nco_clken !== e_busy) begin bad++; $display("FAIL loop_clken k=%0d got=%b exp=%b", k, bus.nco_clken, e_busy); end
      total++; if (bus.done !== e_done) begin bad++; $display("FAIL loop_done k=%0d got=%b exp=%b", k, bus.done, e_done); end
      if (k <= 83) begin
        total++; if (bus.hop_idx !== e_hop) begin bad++; $display("FAIL loop_hop k=%0d got=%0d exp=%0d", k, bus.hop_idx, e_hop); end
      end
      if (k <= 73) begin
        total++; if (bus.settled !== e_set) begin bad++; $display("FAIL loop_settled k=%0d got=%b exp=%b", k, bus.settled, e_set); end
      end
      if (k == 25) begin
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd1; bus.cfg_inc = INC_C; bus.cfg_dwell = 16'd30;
      end else begin
        bus.cfg_we = 1'b0;
      end
      bus.stop = (k == 73);
      @(negedge clk);
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_short_hop();
    cfg_write(3'd0, INC_X, 16'd5);
    cfg_write(3'd1, INC_B, 16'd20);
    bus.last_idx = 3'd1;
    bus.loop_en  = 1'b0;
    pulse_start();
    for (int k = 1; k <= 37; k++) begin
      e_set  = (k >= 16 && k <= 25);
      e_phi  = (k <= 5) ? INC_X : INC_B;
      e_done = (k == 36);
      if (k <= 25) begin
        total++; if (bus.settled !== e_set) begin bad++; $display("FAIL short_settled k=%0d got=%b exp=%b", k, bus.settled, e_set); end
      end
      total++; if (bus.phi_inc_o !== e_phi) begin bad++; $display("FAIL short_phi k=%0d got=%h exp=%h", k, bus.phi_inc_o, e_phi); end
      total++; if (bus.done !== e_done) begin bad++; $display("FAIL short_done k=%0d got=%b exp=%b", k, bus.done, e_done); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored();
    cfg_write(3'd0, INC_A, 16'd20);
    bus.last_idx = 3'd0;
    bus.loop_en  = 1'b0;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL startstop_busy k=%0d got=%b exp=0", k, bus.busy); end
      total++; if (bus.nco_clken !== 1'b0) begin bad++; $display("FAIL startstop_clken k=%0d got=%b exp=0", k, bus.nco_clken); end
      @(negedge clk);
    end
    pulse_start();
    // start in RUN (k=5) and in DRAIN (k=25), stop in DRAIN (k=27): all ignored
    for (int k = 1; k <= 32; k++) begin
      e_busy = (k <= 30);
      e_done = (k == 31);
      total++; if (bus.busy !== e_busy) begin bad++; $display("FAIL ignore_busy k=%0d got=%b exp=%b", k, bus.busy, e_busy); end
      total++; if (bus.done !== e_done) begin bad++; $display("FAIL ignore_done k=%0d got=%b exp=%b", k, bus.done, e_done); end
      total++; if (bus.hop_idx !== 3'd0) begin bad++; $display("FAIL ignore_hop k=%0d got=%0d exp=0", k, bus.hop_idx); end
      bus.start = (k == 5) || (k == 25);
      bus.stop  = (k == 27);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic test_mid_reset();
    cfg_write(3'd0, INC_A, 16'd20);
    bus.last_idx = 3'd0;
    bus.loop_en  = 1'b0;
    pulse_start();
    repeat (14) @(negedge clk);
    total++; if (bus.settled !== 1'b1) begin bad++; $display("FAIL midrst_pre_settled got=%b exp=1", bus.settled); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (bus.phi_inc_o !== 32'h0) begin bad++; $display("FAIL midrst_phi got=%h exp=0", bus.phi_inc_o); end
    total++; if (bus.nco_clken !== 1'b0) begin bad++; $display("FAIL midrst_clken got=%b exp=0", bus.nco_clken); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.settled !== 1'b0) begin bad++; $display("FAIL midrst_settled got=%b exp=0", bus.settled); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_quiet k=%0d got=%b%b exp=00", k, bus.done, bus.busy); end
    end
    // table was cleared: a new run behaves like the empty-table case
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      e_done = (k == 12);
      total++; if (bus.phi_inc_o !== 32'h0) begin bad++; $display("FAIL midrst_tbl_phi k=%0d got=%h exp=0", k, bus.phi_inc_o); end
      total++; if (bus.done !== e_done) begin bad++; $display("FAIL midrst_tbl_done k=%0d got=%b exp=%b", k, bus.done, e_done); end
      @(negedge clk);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_inc   = '0;
    bus.cfg_dwell = '0;
    bus.last_idx  = '0;
    bus.loop_en   = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    @(negedge clk);
    test_reset();
    test_empty_start();
    test_single_pass();
    test_loop();
    test_short_hop();
    test_ignored();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
